adc_read_ad7476: RTL



---
 rtl/adc_read_ad7476_pkg.sv | 15 +
 rtl/adc_read_ad7476_sclk_tick_gen.sv | 30 +++
 rtl/adc_read_ad7476.sv | 139 +++++++++++++
 3 files changed

// File: rtl/adc_read_ad7476_pkg.sv
// Shared types and frame geometry for the AD7476-family serial ADC reader.
package adc_read_ad7476_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CS_SETUP = 2'd1,
        SHIFT    = 2'd2,
        QUIET    = 2'd3
    } state_t;

    localparam int FRAME_BITS = 16;
    localparam int DATA_BITS  = 12;
    localparam int LEAD_BITS  = 4;

endpackage

// File: rtl/adc_read_ad7476_sclk_tick_gen.sv
// sclk half-period divider: tick is high on the last count of each CLK_DIV-cycle period.
// Combinational tick, one cycle wide; clear wins over enable, no backpressure.
module adc_read_ad7476_sclk_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div_cnt;

    assign tick = (div_cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (clr) begin
            div_cnt <= '0;
        end else if (en) begin
            div_cnt <= tick ? '0 : div_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/adc_read_ad7476.sv
// Reads one 16-bit AD7476 frame per start pulse; result + valid strobe 33*CLK_DIV cycles after start.
// start is accepted only in IDLE and never queued; cs held high QUIET_CYC cycles between frames.
module adc_read_ad7476
    import adc_read_ad7476_pkg::*;
#(
    parameter int CLK_DIV   = 4,
    parameter int QUIET_CYC = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        sdout,
    output logic        cs,
    output logic        sclk,
    output logic        busy,
    output logic        valid,
    output logic [11:0] data,
    output logic        lead_err
);

    localparam int QW = $clog2(QUIET_CYC + 1);
    localparam logic [QW-1:0] Q_LAST = QW'(QUIET_CYC - 1);

    state_t                  state, state_nxt;
    logic                    cs_r, cs_nxt;
    logic                    sclk_r, sclk_nxt;
    logic                    valid_r, valid_nxt;
    logic [DATA_BITS-1:0]    data_r, data_nxt;
    logic                    lead_r, lead_nxt;
    logic [FRAME_BITS-1:0]   sreg, sreg_nxt;
    logic [4:0]              bit_cnt, bit_nxt;
    logic [QW-1:0]           q_cnt, q_nxt;
    logic                    sd_q;
    logic                    tick;
    logic                    div_en;

    assign div_en = (state == CS_SETUP) || (state == SHIFT);

    adc_read_ad7476_sclk_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (div_en),
        .clr   (!div_en),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cs_r    <= 1'b1;
            sclk_r  <= 1'b1;
            valid_r <= 1'b0;
            data_r  <= '0;
            lead_r  <= 1'b0;
            sreg    <= '0;
            bit_cnt <= '0;
            q_cnt   <= '0;
            sd_q    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cs_r    <= cs_nxt;
            sclk_r  <= sclk_nxt;
            valid_r <= valid_nxt;
            data_r  <= data_nxt;
            lead_r  <= lead_nxt;
            sreg    <= sreg_nxt;
            bit_cnt <= bit_nxt;
            q_cnt   <= q_nxt;
            sd_q    <= sdout;
        end
    end

    always_comb begin
        state_nxt = state;
        cs_nxt    = cs_r;
        sclk_nxt  = sclk_r;
        valid_nxt = 1'b0;
        data_nxt  = data_r;
        lead_nxt  = lead_r;
        sreg_nxt  = sreg;
        bit_nxt   = bit_cnt;
        q_nxt     = q_cnt;
        case (state)
            IDLE: begin
                cs_nxt   = 1'b1;
                sclk_nxt = 1'b1;
                if (start) begin
                    cs_nxt    = 1'b0;
                    state_nxt = CS_SETUP;
                end
            end
            CS_SETUP: begin
                if (tick) begin
                    sclk_nxt  = 1'b0;
                    bit_nxt   = '0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                // Sample on the rising sclk we drive; the ADC updates on falling edges.
                if (tick) begin
                    if (!sclk_r) begin
                        sclk_nxt = 1'b1;
                        sreg_nxt = {sreg[FRAME_BITS-2:0], sd_q};
                        bit_nxt  = bit_cnt + 5'd1;
                    end else if (bit_cnt < 5'(FRAME_BITS)) begin
                        sclk_nxt = 1'b0;
                    end else begin
                        cs_nxt    = 1'b1;
                        data_nxt  = sreg[DATA_BITS-1:0];
                        lead_nxt  = |sreg[FRAME_BITS-1:DATA_BITS];
                        valid_nxt = 1'b1;
                        q_nxt     = '0;
                        state_nxt = QUIET;
                    end
                end
            end
            QUIET: begin
                cs_nxt   = 1'b1;
                sclk_nxt = 1'b1;
                q_nxt    = q_cnt + 1'b1;
                if (q_cnt == Q_LAST) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign cs       = cs_r;
    assign sclk     = sclk_r;
    assign busy     = (state != IDLE);
    assign valid    = valid_r;
    assign data     = data_r;
    assign lead_err = lead_r;

endmodule
